// File: rtl/can_err_ovld_tx.sv
// CAN error/overload frame transmitter.
// Advanced once per bit time on the sample-point strobe SP. Drives the error or
// overload flag, waits for other nodes' superposed flags to end, checks the
// recessive delimiter and then supervises intermission. An overload may chain
// from intermission, up to MAX_OVLD frames back to back.
module can_err_ovld_tx #(
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8,
  parameter int INTER_LEN = 3,
  parameter int DOM_LIMIT = 14,
  parameter int DOM_STEP  = 8,
  parameter int MAX_OVLD  = 2
) (
  input  logic SP,
  input  logic reset,
  input  logic RX,
  input  logic ERR_REQ,
  input  logic OVLD_REQ,
  input  logic ERROR_PASSIVE,
  output logic TX,
  output logic BUSY,
  output logic FRAME_TYPE,
  output logic DONE,
  output logic DOM_ERR,
  output logic FORM_ERR,
  output logic SOF_DET
);

  localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN)
                         ? ((FLAG_LEN > INTER_LEN) ? FLAG_LEN : INTER_LEN)
                         : ((DELIM_LEN > INTER_LEN) ? DELIM_LEN : INTER_LEN);
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int DOM_W  = $clog2(DOM_LIMIT + 1);
  localparam int STEP_W = $clog2(DOM_STEP + 1);
  localparam int OVLD_W = $clog2(MAX_OVLD + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  FLAG_N     = CNT_W'(FLAG_LEN);
  localparam logic [CNT_W-1:0]  DELIM_LAST = CNT_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0]  INTER_LAST = CNT_W'(INTER_LEN - 1);
  localparam logic [DOM_W-1:0]  DOM_N      = DOM_W'(DOM_LIMIT);
  localparam logic [DOM_W-1:0]  DOM_LAST   = DOM_W'(DOM_LIMIT - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(DOM_STEP - 1);
  localparam logic [OVLD_W-1:0] OVLD_N     = OVLD_W'(MAX_OVLD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLAG     = 3'd1,
    WAIT_REC = 3'd2,
    DELIM    = 3'd3,
    INTER    = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;       // flag bits / passive run / delimiter / intermission bit
  logic               passive;   // current flag is a passive (recessive) error flag
  logic               last_rx;   // previous RX sample, for the passive equal-bit run
  logic [DOM_W-1:0]   dom_cnt;   // dominant bits after the flag, saturates at DOM_LIMIT
  logic [STEP_W-1:0]  step_cnt;  // dominant bits since the last DOM_ERR beyond the limit
  logic [OVLD_W-1:0]  ovld_cnt;  // overload frames in the current chain
  logic [CNT_W-1:0]   run_next;

  // Length of the run of equal RX samples including this one (passive flag).
  always_comb begin
    run_next = CNT_ONE;
    if (cnt != '0 && RX == last_rx) run_next = cnt + CNT_ONE;
  end

  // Frame sequencer with registered bus drive, status and event pulses.
  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      passive    <= 1'b0;
      last_rx    <= 1'b1;
      dom_cnt    <= '0;
      step_cnt   <= '0;
      ovld_cnt   <= '0;
      TX         <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_TYPE <= 1'b0;
      DONE       <= 1'b0;
      DOM_ERR    <= 1'b0;
      FORM_ERR   <= 1'b0;
      SOF_DET    <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      DOM_ERR  <= 1'b0;
      FORM_ERR <= 1'b0;
      SOF_DET  <= 1'b0;
      unique case (state)
        IDLE: begin
          TX   <= 1'b1;
          BUSY <= 1'b0;
          if (ERR_REQ) begin
            state      <= FLAG;
            BUSY       <= 1'b1;
            FRAME_TYPE <= 1'b0;
            ovld_cnt   <= '0;
            passive    <= ERROR_PASSIVE;
            TX         <= ERROR_PASSIVE;
            cnt        <= ERROR_PASSIVE ? '0 : CNT_ONE;
          end else if (OVLD_REQ && ovld_cnt < OVLD_N) begin
            state      <= FLAG;
            BUSY       <= 1'b1;
            FRAME_TYPE <= 1'b1;
            ovld_cnt   <= ovld_cnt + 1'b1;
            passive    <= 1'b0;
            TX         <= 1'b0;
            cnt        <= CNT_ONE;
          end
        end
        FLAG: begin
          if (passive) begin
            // Passive flag ends after FLAG_LEN equal consecutive bus samples.
            last_rx <= RX;
            if (run_next == FLAG_N) begin
              state    <= WAIT_REC;
              cnt      <= '0;
              dom_cnt  <= '0;
              step_cnt <= '0;
            end else begin
              cnt <= run_next;
            end
          end else if (cnt == FLAG_N) begin
            TX       <= 1'b1;
            state    <= WAIT_REC;
            cnt      <= '0;
            dom_cnt  <= '0;
            step_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_REC: begin
          TX <= 1'b1;
          if (!RX) begin
            // Count up to the limit, then keep the cadence on a separate step counter.
            if (dom_cnt != DOM_N) begin
              dom_cnt <= dom_cnt + 1'b1;
              if (dom_cnt == DOM_LAST) DOM_ERR <= 1'b1;
            end else if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              DOM_ERR  <= 1'b1;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end else begin
            state <= DELIM;
            cnt   <= CNT_ONE;
          end
        end
        DELIM: begin
          TX <= 1'b1;
          if (RX) begin
            if (cnt == DELIM_LAST) begin
              state <= INTER;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            // Dominant bit in the delimiter restarts as a fresh error frame.
            FORM_ERR   <= 1'b1;
            state      <= FLAG;
            FRAME_TYPE <= 1'b0;
            ovld_cnt   <= '0;
            passive    <= ERROR_PASSIVE;
            TX         <= ERROR_PASSIVE;
            cnt        <= ERROR_PASSIVE ? '0 : CNT_ONE;
          end
        end
        INTER: begin
          TX <= 1'b1;
          if (cnt == INTER_LAST) begin
            DONE     <= 1'b1;
            SOF_DET  <= ~RX;
            state    <= IDLE;
            BUSY     <= 1'b0;
            ovld_cnt <= '0;
            cnt      <= '0;
          end else if ((!RX || OVLD_REQ) && ovld_cnt < OVLD_N) begin
            state      <= FLAG;
            FRAME_TYPE <= 1'b1;
            ovld_cnt   <= ovld_cnt + 1'b1;
            passive    <= 1'b0;
            TX         <= 1'b0;
            cnt        <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_err_ovld_tx.sv
// Bench for can_err_ovld_tx: directed frame scenarios followed by randomized
// traffic, all compared each bit time against a phase-level reference model.
module tb_can_err_ovld_tx;

  localparam int FLAG_LEN  = 6;
  localparam int DELIM_LEN = 8;
  localparam int INTER_LEN = 3;
  localparam int DOM_LIMIT = 14;
  localparam int DOM_STEP  = 8;
  localparam int MAX_OVLD  = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_FLAG  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_DELIM = 3;
  localparam int PH_INTER = 4;

  logic SP = 1'b0;
  logic reset, RX, ERR_REQ, OVLD_REQ, ERROR_PASSIVE;
  logic TX, BUSY, FRAME_TYPE, DONE, DOM_ERR, FORM_ERR, SOF_DET;

  can_err_ovld_tx #(
    .FLAG_LEN(FLAG_LEN), .DELIM_LEN(DELIM_LEN), .INTER_LEN(INTER_LEN),
    .DOM_LIMIT(DOM_LIMIT), .DOM_STEP(DOM_STEP), .MAX_OVLD(MAX_OVLD)
  ) dut (
    .SP(SP), .reset(reset), .RX(RX), .ERR_REQ(ERR_REQ), .OVLD_REQ(OVLD_REQ),
    .ERROR_PASSIVE(ERROR_PASSIVE), .TX(TX), .BUSY(BUSY), .FRAME_TYPE(FRAME_TYPE),
    .DONE(DONE), .DOM_ERR(DOM_ERR), .FORM_ERR(FORM_ERR), .SOF_DET(SOF_DET)
  );

  always #5 SP = ~SP;

  int n_chk = 0;
  int n_fail = 0;
  int g_cyc = 0;

  // Reference model: frame phase, bits spent in it, unbounded dominant count.
  int   m_ph, m_n, m_dom, m_ovl, m_run;
  bit   m_pas;
  logic m_prev;
  logic e_tx, e_busy, e_ft, e_done, e_dom, e_form, e_sof;

  // Per-scenario observations of the DUT.
  int done_at, dom_first, dom_seen, form_at, tx_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = PH_IDLE; m_n = 0; m_dom = 0; m_ovl = 0; m_run = 0; m_pas = 0; m_prev = 1'b1;
    e_tx = 1'b1; e_busy = 1'b0; e_ft = 1'b0;
    e_done = 1'b0; e_dom = 1'b0; e_form = 1'b0; e_sof = 1'b0;
  endtask

  task automatic m_start(input bit ovl_frame, input logic ep);
    m_ph = PH_FLAG; e_busy = 1'b1; m_n = 1; m_run = 0;
    if (ovl_frame) begin
      e_ft = 1'b1; m_ovl++; m_pas = 0; e_tx = 1'b0;
    end else begin
      e_ft = 1'b0; m_ovl = 0; m_pas = ep; e_tx = ep;
    end
  endtask

  task automatic m_edge(input logic rx, input logic err, input logic ovld, input logic ep);
    e_done = 1'b0; e_dom = 1'b0; e_form = 1'b0; e_sof = 1'b0;
    case (m_ph)
      PH_IDLE: begin
        if (err) m_start(0, ep);
        else if (ovld && m_ovl < MAX_OVLD) m_start(1, ep);
      end
      PH_FLAG: begin
        if (m_pas) begin
          m_run = (m_run > 0 && rx == m_prev) ? m_run + 1 : 1;
          m_prev = rx;
          if (m_run == FLAG_LEN) begin m_ph = PH_WAIT; m_dom = 0; end
        end else if (m_n == FLAG_LEN) begin
          e_tx = 1'b1; m_ph = PH_WAIT; m_dom = 0;
        end else begin
          m_n++;
        end
      end
      PH_WAIT: begin
        if (!rx) begin
          m_dom++;
          e_dom = (m_dom >= DOM_LIMIT) && ((m_dom - DOM_LIMIT) % DOM_STEP == 0);
        end else begin
          m_ph = PH_DELIM; m_n = 1;
        end
      end
      PH_DELIM: begin
        if (rx) begin
          m_n++;
          if (m_n == DELIM_LEN) begin m_ph = PH_INTER; m_n = 0; end
        end else begin
          e_form = 1'b1; m_start(0, ep);
        end
      end
      default: begin
        m_n++;
        if (m_n == INTER_LEN) begin
          e_done = 1'b1; e_sof = ~rx; m_ph = PH_IDLE; e_busy = 1'b0; m_ovl = 0;
        end else if ((!rx || ovld) && m_ovl < MAX_OVLD) begin
          m_start(1, ep);
        end
      end
    endcase
  endtask

  function automatic logic [31:0] outs();
    return 32'({TX, BUSY, FRAME_TYPE, DONE, DOM_ERR, FORM_ERR, SOF_DET});
  endfunction

  function automatic logic [31:0] exps();
    return 32'({e_tx, e_busy, e_ft, e_done, e_dom, e_form, e_sof});
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1; ERR_REQ = 1'b0; OVLD_REQ = 1'b0; ERROR_PASSIVE = 1'b0; RX = 1'b1;
    #2;
    m_reset();
    chk(tag, outs(), exps());
    reset = 1'b0;
  endtask

  task automatic step(input logic err, input logic ovld, input logic ep, input logic rx,
                      input string tag);
    ERR_REQ = err; OVLD_REQ = ovld; ERROR_PASSIVE = ep; RX = rx;
    @(posedge SP);
    m_edge(rx, err, ovld, ep);
    #1;
    chk($sformatf("%s@%0d", tag, g_cyc), outs(), exps());
    g_cyc++;
  endtask

  // One frame from IDLE. Bus is wired-AND of our TX (one bit late) and forced
  // dominant bits on edges f_lo..f_hi. mode 1: passive RX pattern on edges 1..7;
  // mode 2: force dominant at every intermission bit 1.
  task automatic scen(input string tag, input int n, input logic use_ovld, input logic ep,
                      input int f_lo, input int f_hi, input int mode);
    logic f, rx;
    done_at = -1; dom_first = -1; dom_seen = 0; form_at = -1; tx_zero = 0;
    for (int e = 0; e < n; e++) begin
      f  = (e >= f_lo && e <= f_hi) || (mode == 2 && m_ph == PH_INTER && m_n == 0);
      rx = e_tx & ~f;
      if (mode == 1 && e >= 1 && e <= 7) rx = (e == 1);
      step(!use_ovld && e == 0, use_ovld && e == 0, ep, rx, tag);
      if (DONE === 1'b1 && done_at < 0) done_at = e;
      if (DOM_ERR === 1'b1) begin
        dom_seen++;
        if (dom_first < 0) dom_first = e;
      end
      if (FORM_ERR === 1'b1 && form_at < 0) form_at = e;
      if (TX === 1'b0) tx_zero++;
    end
  endtask

  initial begin
    reset = 1'b0; RX = 1'b1; ERR_REQ = 1'b0; OVLD_REQ = 1'b0; ERROR_PASSIVE = 1'b0;
    m_reset();
    do_reset("reset_state");

    // Active error: flag driven after edges 0-5, delimiter samples 7-14,
    // intermission samples 15-17, so DONE shows after edge 17.
    scen("active", 24, 1'b0, 1'b0, -1, -1, 0);
    chk("active_done_edge", 32'(done_at), 32'd17);
    chk("active_flag_bits", 32'(tx_zero), 32'(FLAG_LEN));

    // Superposition: 4 extra dominant samples (edges 7-10) delay DONE by 4.
    do_reset("reset_sup");
    scen("superpos", 28, 1'b0, 1'b0, 7, 10, 0);
    chk("sup_done_edge", 32'(done_at), 32'd21);
    chk("sup_no_dom_err", 32'(dom_seen), 32'd0);

    // Excess dominant: 30 dominant samples, pulses at counts 14, 22, 30.
    do_reset("reset_exc");
    scen("excess", 54, 1'b0, 1'b0, 7, 36, 0);
    chk("exc_dom_pulses", 32'(dom_seen), 32'd3);
    chk("exc_first_dom", 32'(dom_first), 32'd20);
    chk("exc_done_edge", 32'(done_at), 32'd47);

    // Passive error: TX never dominant; run of six 0s ends at edge 7.
    do_reset("reset_pas");
    scen("passive", 24, 1'b0, 1'b1, -1, -1, 1);
    chk("pas_tx_recessive", 32'(tx_zero), 32'd0);
    chk("pas_done_edge", 32'(done_at), 32'd18);

    // Overload chain: one further overload accepted, the next dominant ignored.
    do_reset("reset_ovl");
    scen("ovld_chain", 40, 1'b1, 1'b0, -1, -1, 2);
    chk("ovl_flag_bits", 32'(tx_zero), 32'(2 * FLAG_LEN));
    chk("ovl_done_edge", 32'(done_at), 32'd32);

    // Form error at delimiter bit 4 (edge 10) restarts a 6-bit active flag.
    do_reset("reset_form");
    scen("form_err", 34, 1'b0, 1'b0, 10, 10, 0);
    chk("form_edge", 32'(form_at), 32'd10);
    chk("form_flag_bits", 32'(tx_zero), 32'(2 * FLAG_LEN));
    chk("form_done_edge", 32'(done_at), 32'd27);

    // Reset in the middle of a flag releases the bus without waiting for SP.
    do_reset("reset_mid_pre");
    step(1'b1, 1'b0, 1'b0, 1'b1, "midflag");
    step(1'b0, 1'b0, 1'b0, 1'b0, "midflag");
    step(1'b0, 1'b0, 1'b0, 1'b0, "midflag");
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_tx", 32'(TX), 32'd1);
    chk("mid_reset_busy", 32'(BUSY), 32'd0);
    m_reset();
    #1 reset = 1'b0;

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic f, err, ovl, ep;
      if ($urandom_range(0, 399) == 0) do_reset("rand_reset");
      err = ($urandom_range(0, 30) == 0);
      ovl = ($urandom_range(0, 12) == 0);
      ep  = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 4) == 0);
      step(err, ovl, ep, e_tx & ~f, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
